// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared PPI bus constants, control-word fields and bus-cycle states
package ppi_pkg;

  localparam logic [1:0] ADDR_PORT_A = 2'b00;
  localparam logic [1:0] ADDR_PORT_B = 2'b01;
  localparam logic [1:0] ADDR_PORT_C = 2'b10;
  localparam logic [1:0] ADDR_CTRL   = 2'b11;

  localparam int CW_MODE_SET_BIT = 7;
  localparam int CW_BSR_SEL_MSB  = 3;
  localparam int CW_BSR_SEL_LSB  = 1;
  localparam int CW_BSR_VAL_BIT  = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } bus_state_e;

  // BSR control word: mode-set bit clear, port C bit select and value
  function automatic logic [7:0] bsr_word(input logic [2:0] bit_sel, input logic value);
    return {1'b0, 3'b000, bit_sel, value};
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// rtl/ppi_phase_timer.sv - 4-bit loadable down-counter timing one bus-cycle phase
module ppi_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_value,
  output logic       o_done
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/ppi_host_bus_master.sv
// rtl/ppi_host_bus_master.sv - valid/ready request to timed 8255 CS/RD/WR bus cycle
// Optional macro PPI_BSR_HELPER_EN adds req_bsr for single-bit port C set/reset.
module ppi_host_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [1:0] a,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
`ifdef PPI_BSR_HELPER_EN
  ,
  input  logic       req_bsr
`endif
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVER_CYC < 0 || RECOVER_CYC > 15) begin : g_bad_param
    $error("ppi_host_bus_master: phase cycle parameter out of range");
  end

  localparam logic [3:0] LD_SETUP   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LD_STROBE  = 4'(PULSE_CYC - 1);
  localparam logic [3:0] LD_HOLD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] LD_RECOVER = (RECOVER_CYC == 0) ? 4'd0 : 4'(RECOVER_CYC - 1);

  bus_state_e r_state, w_state_nxt;
  logic       r_write;
  logic       w_accept, w_done, w_load, w_cur_write, w_bus_active;
  logic [3:0] w_load_val;
  logic       w_req_write;
  logic [1:0] w_req_addr;
  logic [7:0] w_req_wdata;
  logic       w_cs_n, w_rd_n, w_wr_n, w_d_oe, w_rsp_valid;
  logic [1:0] w_a;
  logic [7:0] w_d_out, w_rsp_rdata;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

`ifdef PPI_BSR_HELPER_EN
  assign w_req_write = req_bsr ? 1'b1 : req_write;
  assign w_req_addr  = req_bsr ? ADDR_CTRL : req_addr;
  assign w_req_wdata = req_bsr ? bsr_word(req_wdata[CW_BSR_SEL_MSB:CW_BSR_SEL_LSB],
                                          req_wdata[CW_BSR_VAL_BIT]) : req_wdata;
`else
  assign w_req_write = req_write;
  assign w_req_addr  = req_addr;
  assign w_req_wdata = req_wdata;
`endif

  ppi_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_value(w_load_val),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_write <= w_req_write;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   if (w_done) w_state_nxt = STROBE;
      STROBE:  if (w_done) w_state_nxt = HOLD;
      HOLD:    if (w_done) w_state_nxt = (RECOVER_CYC == 0) ? IDLE : RECOVER;
      RECOVER: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Every phase differs from its predecessor, so a state change marks a phase entry.
  always_comb begin
    w_load = (w_state_nxt != r_state);
    case (w_state_nxt)
      SETUP:   w_load_val = LD_SETUP;
      STROBE:  w_load_val = LD_STROBE;
      HOLD:    w_load_val = LD_HOLD;
      RECOVER: w_load_val = LD_RECOVER;
      default: w_load_val = 4'd0;
    endcase
  end

  always_comb begin
    w_cur_write  = w_accept ? w_req_write : r_write;
    w_bus_active = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) || (w_state_nxt == HOLD);
    w_cs_n       = !w_bus_active;
    w_rd_n       = !((w_state_nxt == STROBE) && !w_cur_write);
    w_wr_n       = !((w_state_nxt == STROBE) && w_cur_write);
    w_d_oe       = w_bus_active && w_cur_write;
    w_a          = w_accept ? w_req_addr : a;
    w_d_out      = (w_accept && w_req_write) ? w_req_wdata : d_out;
    w_rsp_valid  = (r_state == HOLD) && w_done;
    w_rsp_rdata  = ((r_state == STROBE) && w_done && !r_write) ? d_in : rsp_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a         <= 2'b00;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      cs_n      <= w_cs_n;
      rd_n      <= w_rd_n;
      wr_n      <= w_wr_n;
      a         <= w_a;
      d_out     <= w_d_out;
      d_oe      <= w_d_oe;
      rsp_valid <= w_rsp_valid;
      rsp_rdata <= w_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_ppi_host_bus_master.sv
// tb/tb_ppi_host_bus_master.sv - directed and randomized bench with a cycle-window bus model
module tb_ppi_host_bus_master;

  localparam int S_CYC [2] = '{1, 2};
  localparam int P_CYC [2] = '{2, 3};
  localparam int H_CYC [2] = '{1, 1};
  localparam int R_CYC [2] = '{1, 0};

  logic       clk;
  logic       reset     [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [1:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       req_bsr   [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       cs_n      [2];
  logic       rd_n      [2];
  logic       wr_n      [2];
  logic [1:0] a         [2];
  logic [7:0] d_out     [2];
  logic       d_oe      [2];
  logic [7:0] d_in      [2];

  logic [7:0] m_rdata [2];
  logic [7:0] m_dout  [2];
  int n_cmp;
  int n_err;

  ppi_host_bus_master #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .RECOVER_CYC(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]),
    .wr_n(wr_n[0]), .a(a[0]), .d_out(d_out[0]), .d_oe(d_oe[0]), .d_in(d_in[0])
`ifdef PPI_BSR_HELPER_EN
    , .req_bsr(req_bsr[0])
`endif
  );

  ppi_host_bus_master #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1), .RECOVER_CYC(0)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]),
    .wr_n(wr_n[1]), .a(a[1]), .d_out(d_out[1]), .d_oe(d_oe[1]), .d_in(d_in[1])
`ifdef PPI_BSR_HELPER_EN
    , .req_bsr(req_bsr[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int u, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input int u, input string tag);
    chk({tag, "_cs_n"}, u, cs_n[u], 1);
    chk({tag, "_rd_n"}, u, rd_n[u], 1);
    chk({tag, "_wr_n"}, u, wr_n[u], 1);
    chk({tag, "_d_oe"}, u, d_oe[u], 0);
    chk({tag, "_a"}, u, a[u], 0);
    chk({tag, "_d_out"}, u, d_out[u], 0);
    chk({tag, "_rsp_valid"}, u, rsp_valid[u], 0);
    chk({tag, "_rsp_rdata"}, u, rsp_rdata[u], 0);
    chk({tag, "_req_ready"}, u, req_ready[u], 0);
  endtask

  // Cycle k counts periods after the accepting edge: cs_n low for k < S+P+H,
  // strobe low for S <= k < S+P, rsp_valid at k == S+P+H.
  task automatic bus_req(input int u, input logic wr, input logic [1:0] addr,
                         input logic [7:0] wd, input logic bsr, input logic [7:0] rdval,
                         input bit noisy, input int abort_k);
    logic       ewr;
    logic [1:0] eaddr;
    logic [7:0] ewd;
    int lat, waits;
    bit strobe_win;
    ewr = wr;
    eaddr = addr;
    ewd = wd;
`ifdef PPI_BSR_HELPER_EN
    if (bsr) begin
      ewr = 1'b1;
      eaddr = 2'b11;
      ewd = {4'b0000, wd[3:0]};
    end
`endif
    lat = S_CYC[u] + P_CYC[u] + H_CYC[u];
    waits = 0;
    req_valid[u] = 1'b0;
    while (req_ready[u] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("ready_wait", u, req_ready[u], 1);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    req_bsr[u]   = bsr;
    d_in[u]      = 8'($urandom);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (noisy && k < lat) begin
        req_valid[u] = 1'($urandom);
        req_write[u] = 1'($urandom);
        req_addr[u]  = 2'($urandom);
        req_wdata[u] = 8'($urandom);
        req_bsr[u]   = 1'($urandom);
      end else begin
        req_valid[u] = 1'b0;
      end
      strobe_win = (k >= S_CYC[u]) && (k < S_CYC[u] + P_CYC[u]);
      chk("cs_n", u, cs_n[u], (k < lat) ? 1'b0 : 1'b1);
      chk("rd_n", u, rd_n[u], !(strobe_win && !ewr));
      chk("wr_n", u, wr_n[u], !(strobe_win && ewr));
      chk("d_oe", u, d_oe[u], (k < lat) && ewr);
      chk("a", u, a[u], eaddr);
      chk("d_out", u, d_out[u], ewr ? ewd : m_dout[u]);
      chk("rsp_valid", u, rsp_valid[u], k == lat);
      chk("req_ready", u, req_ready[u], (k == lat) && (R_CYC[u] == 0));
      if (k == lat) begin
        if (!ewr) m_rdata[u] = rdval;
        chk("rsp_rdata", u, rsp_rdata[u], m_rdata[u]);
      end
      d_in[u] = strobe_win ? rdval : 8'($urandom);
      if (k == abort_k) begin
        reset[u] = 1'b1;
        @(negedge clk);
        chk_reset_state(u, "abort");
        reset[u] = 1'b0;
        m_rdata[u] = 8'h00;
        m_dout[u]  = 8'h00;
        @(negedge clk);
        chk("abort_no_rsp", u, rsp_valid[u], 0);
        chk("abort_ready", u, req_ready[u], 1);
        return;
      end
    end
    if (ewr) m_dout[u] = ewd;
    req_valid[u] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u] = 2'b00;
      req_wdata[u] = 8'h00;
      req_bsr[u] = 1'b0;
      d_in[u] = 8'h00;
      m_rdata[u] = 8'h00;
      m_dout[u] = 8'h00;
    end
    repeat (2) @(negedge clk);
    chk_reset_state(0, "rst");
    chk_reset_state(1, "rst");
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);

    bus_req(0, 1'b1, 2'b11, 8'h80, 1'b0, 8'h00, 1'b0, -1);
    bus_req(0, 1'b0, 2'b01, 8'h00, 1'b0, 8'h5A, 1'b0, -1);
    bus_req(0, 1'b1, 2'b10, 8'hC3, 1'b0, 8'h00, 1'b0, -1);

    bus_req(1, 1'b1, 2'b00, 8'h11, 1'b0, 8'h00, 1'b0, -1);
    bus_req(1, 1'b1, 2'b00, 8'h22, 1'b0, 8'h00, 1'b0, -1);
    bus_req(1, 1'b0, 2'b10, 8'h00, 1'b0, 8'hA7, 1'b0, -1);

    bus_req(0, 1'b1, 2'b10, 8'h3C, 1'b0, 8'h00, 1'b0, 2);
    bus_req(0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h96, 1'b0, -1);

`ifdef PPI_BSR_HELPER_EN
    bus_req(0, 1'b0, 2'b00, 8'hAB, 1'b1, 8'h00, 1'b0, -1);
    bus_req(1, 1'b0, 2'b01, 8'h5B, 1'b1, 8'h00, 1'b0, -1);
`endif

    for (int i = 0; i < 24; i++) begin
      bus_req(i % 2, 1'($urandom), 2'($urandom), 8'($urandom), 1'b0, 8'($urandom), 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
